// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- single-entry write-back / commit stage.
//
// Purpose:
//   Accepts one instruction per cycle from MEM. The final register result is
//   formed at accept time: the ALU result, or a value extracted from the
//   aligned load word. The stage holds that result until the next cycle and
//   then commits it. A commit writes the GPR file, pulses o_retire, and bumps
//   the 64-bit retire counter. A misaligned load pulses o_ld_misalign
//   instead. i_dbg_halt freezes commit and back-pressures MEM.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_mem_vld/o_mem_rdy valid/ready handshake with MEM
//   i_mem_rd_we/addr    destination register write enable / index
//   i_mem_is_load       result comes from load data rather than ALU
//   i_mem_ld_funct3     load type (LB/LH/LW/LBU/LHU)
//   i_mem_addr_lo       load byte address bits [1:0]
//   i_mem_alu_res       ALU/CSR result
//   i_mem_ld_word       raw aligned word from data memory
//   i_dbg_halt          debug halt, freezes commit
//   o_wb_wr_*           GPR write port
//   o_retire            one-cycle pulse per committed instruction
//   o_ld_misalign       one-cycle pulse when a misaligned load commits
//   o_retire_cnt        retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_vld,
  output logic              o_mem_rdy,
  input  logic              i_mem_rd_we,
  input  logic [REG_AW-1:0] i_mem_rd_addr,
  input  logic              i_mem_is_load,
  input  logic [2:0]        i_mem_ld_funct3,
  input  logic [1:0]        i_mem_addr_lo,
  input  logic [XLEN-1:0]   i_mem_alu_res,
  input  logic [XLEN-1:0]   i_mem_ld_word,
  input  logic              i_dbg_halt,
  output logic              o_wb_wr_en,
  output logic [REG_AW-1:0] o_wb_wr_addr,
  output logic [XLEN-1:0]   o_wb_wr_data,
  output logic              o_retire,
  output logic              o_ld_misalign,
  output logic [63:0]       o_retire_cnt
);

  // Held entry
  logic              r_vld_reg;
  logic              rd_we_reg;
  logic [REG_AW-1:0] rd_addr_reg;
  logic              misalign_reg;
  logic [XLEN-1:0]   data_reg;
  logic [63:0]       retire_cnt_reg;

  // Values latched on accept
  logic              misalign_next;
  logic [XLEN-1:0]   data_next;

  logic              commit;
  logic              accept;

  // Load extraction helpers
  logic [7:0]        ld_bytes [4];
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              ld_signed;
  logic [XLEN-1:0]   ld_data;
  logic              ld_misalign;

  // Holding rst_n low suppresses commit, so a pending entry is dropped
  // without a GPR write while MEM still sees ready.
  assign commit    = r_vld_reg && !i_dbg_halt && rst_n;
  assign o_mem_rdy = !rst_n || !r_vld_reg || commit;
  assign accept    = i_mem_vld && o_mem_rdy;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ld_byte
      assign ld_bytes[gi] = i_mem_ld_word[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_sel    = ld_bytes[i_mem_addr_lo];
    // Halfword lane picks on addr bit 1 only; odd addresses are flagged
    // misaligned, so the data is never written in that case.
    half_sel    = i_mem_addr_lo[1] ? i_mem_ld_word[31:16] : i_mem_ld_word[15:0];
    ld_signed   = !i_mem_ld_funct3[2];
    ld_data     = '0;
    ld_misalign = 1'b0;
    case (i_mem_ld_funct3)
      3'b000, 3'b100: begin
        ld_data     = {{(XLEN-8){ld_signed & byte_sel[7]}}, byte_sel};
        ld_misalign = 1'b0;
      end
      3'b001, 3'b101: begin
        ld_data     = {{(XLEN-16){ld_signed & half_sel[15]}}, half_sel};
        ld_misalign = i_mem_addr_lo[0];
      end
      3'b010: begin
        ld_data     = i_mem_ld_word;
        ld_misalign = (i_mem_addr_lo != 2'b00);
      end
      default: begin
        // Reserved load encodings are reported as misaligned loads.
        ld_data     = '0;
        ld_misalign = 1'b1;
      end
    endcase
    data_next     = i_mem_is_load ? ld_data : i_mem_alu_res;
    misalign_next = i_mem_is_load && ld_misalign;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_reg      <= 1'b0;
      rd_we_reg      <= 1'b0;
      rd_addr_reg    <= '0;
      misalign_reg   <= 1'b0;
      data_reg       <= '0;
      retire_cnt_reg <= '0;
    end else begin
      if (accept) begin
        r_vld_reg    <= 1'b1;
        rd_we_reg    <= i_mem_rd_we;
        rd_addr_reg  <= i_mem_rd_addr;
        misalign_reg <= misalign_next;
        data_reg     <= data_next;
      end else if (commit) begin
        r_vld_reg    <= 1'b0;
      end
      if (o_retire) begin
        retire_cnt_reg <= retire_cnt_reg + 64'd1;
      end
    end
  end

  assign o_wb_wr_en    = commit && rd_we_reg && (rd_addr_reg != '0) && !misalign_reg;
  assign o_wb_wr_addr  = rd_addr_reg;
  assign o_wb_wr_data  = data_reg;
  assign o_retire      = commit && !misalign_reg;
  assign o_ld_misalign = commit && misalign_reg;
  assign o_retire_cnt  = retire_cnt_reg;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_mem_vld;
  logic        o_mem_rdy;
  logic        i_mem_rd_we;
  logic [4:0]  i_mem_rd_addr;
  logic        i_mem_is_load;
  logic [2:0]  i_mem_ld_funct3;
  logic [1:0]  i_mem_addr_lo;
  logic [31:0] i_mem_alu_res;
  logic [31:0] i_mem_ld_word;
  logic        i_dbg_halt;
  logic        o_wb_wr_en;
  logic [4:0]  o_wb_wr_addr;
  logic [31:0] o_wb_wr_data;
  logic        o_retire;
  logic        o_ld_misalign;
  logic [63:0] o_retire_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the stage should be holding.
  logic        m_vld;
  logic        m_we;
  logic [4:0]  m_addr;
  logic        m_mis;
  logic [31:0] m_data;
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_mem_vld      (i_mem_vld),
    .o_mem_rdy      (o_mem_rdy),
    .i_mem_rd_we    (i_mem_rd_we),
    .i_mem_rd_addr  (i_mem_rd_addr),
    .i_mem_is_load  (i_mem_is_load),
    .i_mem_ld_funct3(i_mem_ld_funct3),
    .i_mem_addr_lo  (i_mem_addr_lo),
    .i_mem_alu_res  (i_mem_alu_res),
    .i_mem_ld_word  (i_mem_ld_word),
    .i_dbg_halt     (i_dbg_halt),
    .o_wb_wr_en     (o_wb_wr_en),
    .o_wb_wr_addr   (o_wb_wr_addr),
    .o_wb_wr_data   (o_wb_wr_data),
    .o_retire       (o_retire),
    .o_ld_misalign  (o_ld_misalign),
    .o_retire_cnt   (o_retire_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Loaded value computed arithmetically from the byte offset.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    int unsigned off;
    int unsigned v;
    off = 8 * int'(lo);
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> off) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (w >> off) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      3'd2: v = w;
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic ref_mis(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (int'(lo) % 2) != 0;
      3'd2:       return (int'(lo) % 4) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  task automatic drive(input logic vld, input logic we, input logic [4:0] addr,
                       input logic ld, input logic [2:0] f3, input logic [1:0] lo,
                       input logic [31:0] alu, input logic [31:0] word, input logic halt);
    i_mem_vld       = vld;
    i_mem_rd_we     = we;
    i_mem_rd_addr   = addr;
    i_mem_is_load   = ld;
    i_mem_ld_funct3 = f3;
    i_mem_addr_lo   = lo;
    i_mem_alu_res   = alu;
    i_mem_ld_word   = word;
    i_dbg_halt      = halt;
  endtask

  task automatic idle(input logic halt);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, halt);
  endtask

  // Called at the negedge: compare against the model, advance it, cross the edge.
  task automatic step();
    logic exp_commit, exp_rdy, exp_we;
    exp_commit = m_vld && !i_dbg_halt;
    exp_rdy    = !m_vld || exp_commit;
    exp_we     = exp_commit && m_we && (m_addr != 5'd0) && !m_mis;
    check("rdy",         64'(o_mem_rdy),     64'(exp_rdy));
    check("wr_en",       64'(o_wb_wr_en),    64'(exp_we));
    check("retire",      64'(o_retire),      64'(exp_commit && !m_mis));
    check("ld_misalign", 64'(o_ld_misalign), 64'(exp_commit && m_mis));
    check("retire_cnt",  o_retire_cnt,       m_cnt);
    check("wr_addr",     64'(o_wb_wr_addr),  64'(m_addr));
    if (exp_we) check("wr_data", 64'(o_wb_wr_data), 64'(m_data));
    if (exp_commit && !m_mis) m_cnt = m_cnt + 64'd1;
    if (i_mem_vld && exp_rdy) begin
      m_vld  = 1'b1;
      m_we   = i_mem_rd_we;
      m_addr = i_mem_rd_addr;
      m_mis  = i_mem_is_load && ref_mis(i_mem_ld_funct3, i_mem_addr_lo);
      m_data = i_mem_is_load ? ref_load(i_mem_ld_funct3, i_mem_addr_lo, i_mem_ld_word)
                             : i_mem_alu_res;
    end else if (exp_commit) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    step();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_wr_en",    64'(o_wb_wr_en),    64'd0);
      check("rst_retire",   64'(o_retire),      64'd0);
      check("rst_misalign", 64'(o_ld_misalign), 64'd0);
      check("rst_rdy",      64'(o_mem_rdy),     64'd1);
      @(posedge clk);
      #1;
    end
    m_vld = 1'b0; m_we = 1'b0; m_addr = 5'd0; m_mis = 1'b0; m_data = 32'h0; m_cnt = 64'd0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_wr_data", 64'(o_wb_wr_data), 64'd0);
    check("rst_cnt",     o_retire_cnt,      64'd0);
    step();
  endtask

  typedef struct {
    logic        is_load;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] word;
    logic [31:0] alu;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [12];

  initial begin
    rst_n = 1'b0;
    idle(1'b0);
    m_vld = 1'b0; m_we = 1'b0; m_addr = 5'd0; m_mis = 1'b0; m_data = 32'h0; m_cnt = 64'd0;

    vecs[0]  = '{1'b0, 3'd0, 2'd0, 32'h0,         32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 2'd3, 32'h80FF_7F01, 32'h0,         32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{1'b1, 3'd4, 2'd1, 32'h80FF_7F01, 32'h0,         32'h0000_007F, 1'b0};
    vecs[3]  = '{1'b1, 3'd1, 2'd2, 32'h80FF_7F01, 32'h0,         32'hFFFF_80FF, 1'b0};
    vecs[4]  = '{1'b1, 3'd5, 2'd0, 32'h80FF_7F01, 32'h0,         32'h0000_7F01, 1'b0};
    vecs[5]  = '{1'b1, 3'd0, 2'd2, 32'h80FF_7F01, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{1'b1, 3'd0, 2'd0, 32'h80FF_7F01, 32'h0,         32'h0000_0001, 1'b0};
    vecs[7]  = '{1'b1, 3'd2, 2'd0, 32'h80FF_7F01, 32'h0,         32'h80FF_7F01, 1'b0};
    vecs[8]  = '{1'b1, 3'd2, 2'd2, 32'h80FF_7F01, 32'h0,         32'h0,         1'b1};
    vecs[9]  = '{1'b1, 3'd1, 2'd1, 32'h80FF_7F01, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{1'b1, 3'd3, 2'd0, 32'h80FF_7F01, 32'h0,         32'h0,         1'b1};
    vecs[11] = '{1'b1, 3'd5, 2'd2, 32'h80FF_7F01, 32'h0,         32'h0000_80FF, 1'b0};

    do_reset(2);

    // Single ALU op: commits the following cycle, count becomes 1.
    drive(1'b1, 1'b1, 5'd5, 1'b0, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 1'b0);
    tick();
    idle(1'b0);
    @(negedge clk);
    check("alu_wr_en",   64'(o_wb_wr_en),   64'd1);
    check("alu_wr_addr", 64'(o_wb_wr_addr), 64'd5);
    check("alu_wr_data", 64'(o_wb_wr_data), 64'h1234_5678);
    step();
    check("alu_cnt", o_retire_cnt, 64'd1);

    // Table of result-extraction vectors.
    foreach (vecs[k]) begin
      logic [63:0] cnt_before;
      drive(1'b1, 1'b1, 5'd7, vecs[k].is_load, vecs[k].f3, vecs[k].lo,
            vecs[k].alu, vecs[k].word, 1'b0);
      tick();
      idle(1'b0);
      @(negedge clk);
      cnt_before = o_retire_cnt;
      check("vec_misalign", 64'(o_ld_misalign), 64'(vecs[k].exp_mis));
      check("vec_wr_en",    64'(o_wb_wr_en),    64'(!vecs[k].exp_mis));
      if (!vecs[k].exp_mis) check("vec_data", 64'(o_wb_wr_data), 64'(vecs[k].exp_data));
      step();
      check("vec_cnt", o_retire_cnt, cnt_before + (vecs[k].exp_mis ? 64'd0 : 64'd1));
      $display("vec %0d f3=%0d lo=%0d data=0x%08h misalign=%0b", k, vecs[k].f3, vecs[k].lo,
               vecs[k].exp_data, vecs[k].exp_mis);
    end

    // Back-to-back ALU ops, then a write to x0.
    do_reset(1);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, 5'(i), 1'b0, 3'd0, 2'd0, 32'h100 + 32'(i), 32'h0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 5'd0, 1'b0, 3'd0, 2'd0, 32'hABCD, 32'h0, 1'b0);
    tick();
    idle(1'b0);
    @(negedge clk);
    check("b2b_cnt",     o_retire_cnt,     64'd4);
    check("x0_retire",   64'(o_retire),    64'd1);
    check("x0_wr_en",    64'(o_wb_wr_en),  64'd0);
    step();
    check("x0_cnt", o_retire_cnt, 64'd5);
    $display("back-to-back: cnt=%0d", o_retire_cnt);

    // Debug halt for three cycles while a new instruction is offered.
    do_reset(1);
    drive(1'b1, 1'b1, 5'd9, 1'b0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd10, 1'b0, 3'd0, 2'd0, 32'h0BAD_F00D, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_rdy",   64'(o_mem_rdy),  64'd0);
      check("halt_wr_en", 64'(o_wb_wr_en), 64'd0);
      check("halt_cnt",   o_retire_cnt,    64'd0);
      step();
    end
    i_dbg_halt = 1'b0;
    @(negedge clk);
    check("unhalt_wr_en", 64'(o_wb_wr_en),   64'd1);
    check("unhalt_data",  64'(o_wb_wr_data), 64'hDEAD_BEEF);
    check("unhalt_rdy",   64'(o_mem_rdy),    64'd1);
    step();
    idle(1'b0);
    @(negedge clk);
    check("unhalt_next_data", 64'(o_wb_wr_data), 64'h0BAD_F00D);
    step();
    $display("halt release: cnt=%0d", o_retire_cnt);

    // Reset while an entry is pending.
    drive(1'b1, 1'b1, 5'd12, 1'b0, 3'd0, 2'd0, 32'h5555_AAAA, 32'h0, 1'b0);
    tick();
    idle(1'b0);
    do_reset(1);
    check("rst_pending_cnt", o_retire_cnt, 64'd0);
    $display("reset with pending entry: cnt=%0d", o_retire_cnt);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom),
            1'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom,
            1'($urandom_range(0, 4) == 0));
      tick();
    end
    idle(1'b0);
    tick();
    tick();
    $display("random: cnt=%0d", o_retire_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, 32, register data width; only 32 is supported.
REQ-002 Parameter REG_AW, 5, register address width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_mem_vld  in  1  MEM stage presents an instruction.
REQ-006 o_mem_rdy  out  1  WB can accept this cycle.
REQ-007 i_mem_rd_we  in  1  instruction writes rd.
REQ-008 i_mem_rd_addr  in  REG_AW  destination register.
REQ-009 i_mem_is_load  in  1  result comes from load data, not ALU.
REQ-010 i_mem_ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 i_mem_addr_lo  in  2  load byte address bits [1:0].
REQ-012 i_mem_alu_res  in  XLEN  ALU/CSR result.
REQ-013 i_mem_ld_word  in  XLEN  raw aligned 32-bit word read from data memory.
REQ-014 i_dbg_halt  in  1  debug halt; freezes commit.
REQ-015 o_wb_wr_en  out  1  GPR write enable (to register file write port).
REQ-016 o_wb_wr_addr  out  REG_AW  GPR write address.
REQ-017 o_wb_wr_data  out  XLEN  GPR write data.
REQ-018 o_retire  out  1  one-cycle pulse per committed instruction.
REQ-019 o_ld_misalign  out  1  one-cycle pulse when a misaligned load reaches commit.
REQ-020 o_retire_cnt  out  64  retired-instruction count.

Function
REQ-021 WB holds one entry (r_vld plus payload); accept = i_mem_vld && o_mem_rdy.
REQ-022 commit = r_vld && !i_dbg_halt; o_mem_rdy = !r_vld || commit (combinational, same-cycle refill allowed).
REQ-023 On accept: r_vld<=1; rd_we, rd_addr, misalign flag and final result data are latched; without accept and with commit, r_vld<=0; otherwise hold.
REQ-024 Result data is computed at accept: ALU result if !is_load; otherwise extracted from i_mem_ld_word.
REQ-025 LB/LBU: byte = word[8*addr_lo+7 : 8*addr_lo], sign- or zero-extended to 32 bits.
REQ-026 LH/LHU: half = word[15:0] if addr_lo=00, word[31:16] if addr_lo=10; sign- or zero-extended.
REQ-027 LW: data = word.
REQ-028 Misaligned: LH/LHU with addr_lo[0]=1, or LW with addr_lo!=00; reserved funct3 (011,110,111) with is_load is also flagged misaligned.
REQ-029 o_wb_wr_en = commit && rd_we && (rd_addr!=0) && !misalign; o_wb_wr_addr/o_wb_wr_data driven from entry every cycle.
REQ-030 o_retire = commit && !misalign; o_ld_misalign = commit && misalign.
REQ-031 o_retire_cnt increments by 1 on o_retire, wraps 2^64-1 -> 0.
REQ-032 Latency: an instruction accepted at edge N commits in cycle N+1 if not halted; sustained throughput 1/cycle.
REQ-033 During i_dbg_halt, entry, outputs and counter are held; no GPR write; o_mem_rdy=0 while r_vld=1.
REQ-034 Halt deassert: the held entry commits in that same cycle.
REQ-035 Writes to x0 still retire and count but never assert o_wb_wr_en.

Reset
REQ-036 On rst_n=0 at a clock edge: r_vld=0, payload=0, o_retire_cnt=0; a pending entry is discarded without write.
REQ-037 During and after reset until the first accept: o_wb_wr_en=0, o_retire=0, o_ld_misalign=0, o_mem_rdy=1 (halt deasserted).

Verification
REQ-038 ALU: rd_we=1, rd=5, alu_res=0x1234_5678 -> next cycle wr_en=1, addr=5, data=0x1234_5678, retire=1, cnt=1.
REQ-039 Loads, word=0x80FF_7F01: LB lo=11 -> 0xFFFF_FF80; LBU lo=01 -> 0x0000_007F; LH lo=10 -> 0xFFFF_80FF; LHU lo=00 -> 0x0000_7F01.
REQ-040 LW lo=10, rd=3 -> ld_misalign=1, wr_en=0, retire=0, cnt unchanged.
REQ-041 Back-to-back 4 ALU ops with vld=1 -> rdy stays 1, 4 consecutive writes, cnt=4; rd=0 op -> retire=1, wr_en=0.
REQ-042 i_dbg_halt=1 for 3 cycles with entry held -> rdy=0, no write, cnt frozen; deassert -> write and retire that cycle.
REQ-043 Assert rst_n=0 with r_vld=1 -> no write, cnt=0, rdy=1 after reset.
